// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and helpers for the CLA issue-control slice.
//   clog2          : ceiling log2, usable in parameter and port declarations
//   CLA_DEFAULT_N  : default operand width of the CLA adder
//   CLA_ADD_LAT    : adder latency, the single source shared by every user
//   cla_stat_t     : width of the optional statistics counters
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_DEFAULT_N = 4;
  localparam int CLA_ADD_LAT   = 5;
  localparam int CLA_STAT_W    = 16;

  typedef logic [CLA_STAT_W-1:0] cla_stat_t;

  // Ceiling log2; clog2(1) = 0, clog2(8) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : cla_pkg

// File: rtl/cla_sum_fifo.sv
// -----------------------------------------------------------------------------
// cla_sum_fifo
// Synchronous FIFO that holds adder results until the consumer takes them.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   wr_en_i      : write wr_data_i this cycle
//   wr_data_i    : data to write
//   rd_en_i      : pop the head this cycle (ignored when empty)
//   rd_data_o    : head entry, zero when empty
//   valid_o      : FIFO holds at least one entry
//   count_o      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// A write into an empty FIFO shows up on rd_data_o the following cycle;
// there is no bypass path from wr_data_i to rd_data_o.
// -----------------------------------------------------------------------------
module cla_sum_fifo
  import cla_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   valid_o,
  output logic [clog2(DEPTH):0]  count_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // A write with the FIFO full is dropped here; upstream credits make that
  // case unreachable and the assertion below flags it if it ever happens.
  assign do_wr = wr_en_i & (count_q != FULL_C);
  assign do_rd = rd_en_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign valid_o   = (count_q != '0);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(wr_en_i && (count_q == FULL_C)));

endmodule : cla_sum_fifo

// File: rtl/cla_issue_ctrl.sv
// -----------------------------------------------------------------------------
// cla_issue_ctrl
// Flow-control shell around a pipelined, stall-less N-bit CLA adder.
// Operand pairs enter on a valid/ready interface, are driven into the adder,
// and every sum is captured into an output FIFO read on valid/ready.
// Credit-based issue guarantees the FIFO always has room for every sum that
// is still travelling through the adder, so no result can be dropped.
//
// Handshake (both interfaces): a transfer happens in a cycle where valid and
// ready are both high at the rising edge. in_ready depends only on registered
// state and reset; out_valid/out_sum depend only on FIFO state. Upstream may
// drop in_valid at any time; out_sum is held stable while out_valid is high
// and out_ready is low.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset (shared
//                           with the adder)
//   in_valid/in_ready     : operand handshake
//   in_a, in_b            : operands
//   add_a, add_b          : operands to the adder, zero in non-accept cycles
//   add_sum               : adder result, ADD_LAT cycles after add_a/add_b
//                           (the presenting cycle counts as the first)
//   out_valid/out_ready   : result handshake
//   out_sum               : FIFO head, carry in bit N, zero when empty
//   stat_ops, stat_carry  : only with CLA_ISSUE_STATS_EN defined; count pops
//                           and pops whose carry bit is set, wrap at 2^16
//
// Build option: define CLA_ISSUE_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module cla_issue_ctrl
  import cla_pkg::*;
#(
  parameter int N       = CLA_DEFAULT_N,
  parameter int ADD_LAT = CLA_ADD_LAT,
  parameter int DEPTH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N:0]   add_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_sum
`ifdef CLA_ISSUE_STATS_EN
  ,
  output cla_stat_t    stat_ops,
  output cla_stat_t    stat_carry
`endif
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          accept;
  logic          pop;
  logic          fifo_wr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] credits_q, credits_d;

  // One credit per FIFO slot. A credit is taken when an op is accepted and
  // returned when its result is popped, so credits_q = fifo_count + inflight.
  assign in_ready = (credits_q < DEPTH_C) & ~reset;
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // The adder samples every cycle; idle cycles carry zeros that are never
  // captured because no token travels with them.
  assign add_a = accept ? in_a : '0;
  assign add_b = accept ? in_b : '0;

  // Token pipe. tok[0] is the op being presented this cycle and tok[k] the
  // op presented k cycles ago, so tok[ADD_LAT-1] is high exactly in the
  // cycle the adder shows that op's sum; it is captured at the closing edge.
  generate
    if (ADD_LAT > 1) begin : g_tok
      logic [ADD_LAT-2:0] tok_q;
      logic [ADD_LAT-1:0] tok;

      assign tok     = {tok_q, accept};
      assign fifo_wr = tok[ADD_LAT-1];

      always_ff @(posedge clk) begin
        if (reset) tok_q <= '0;
        else       tok_q <= tok[ADD_LAT-2:0];
      end

      a_credit_balance : assert property (@(posedge clk) disable iff (reset)
        credits_q == fifo_count + CW'($countones(tok_q)));
    end else begin : g_no_tok
      // Single-cycle adder: the sum is on add_sum in the accept cycle.
      assign fifo_wr = accept;

      a_credit_balance : assert property (@(posedge clk) disable iff (reset)
        credits_q == fifo_count);
    end
  endgenerate

  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) credits_q <= '0;
    else       credits_q <= credits_d;
  end

  cla_sum_fifo #(
    .WIDTH (N + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifo_wr),
    .wr_data_i (add_sum),
    .rd_en_i   (pop),
    .rd_data_o (out_sum),
    .valid_o   (out_valid),
    .count_o   (fifo_count)
  );

`ifdef CLA_ISSUE_STATS_EN
  cla_stat_t stat_ops_q, stat_carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops_q   <= '0;
      stat_carry_q <= '0;
    end else if (pop) begin
      stat_ops_q <= stat_ops_q + CLA_STAT_W'(1);
      if (out_sum[N]) stat_carry_q <= stat_carry_q + CLA_STAT_W'(1);
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_carry = stat_carry_q;
`endif

endmodule : cla_issue_ctrl

// File: tb/tb_cla_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cla_issue_ctrl
// Directed bench for cla_issue_ctrl with a behavioural pipelined adder.
// Accepted operand pairs push their hand-computed sum into exp_q; a monitor
// pops and compares on every out_valid & out_ready cycle. Timing of
// in_ready/out_valid is checked per cycle inside each directed scenario.
// Define CLA_ISSUE_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_cla_issue_ctrl;
  import cla_pkg::*;

  localparam int N       = CLA_DEFAULT_N;
  localparam int ADD_LAT = CLA_ADD_LAT;
  localparam int DEPTH   = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic         in_valid, in_ready;
  logic [N-1:0] in_a, in_b;
  logic [N-1:0] add_a, add_b;
  logic [N:0]   add_sum;
  logic         out_valid, out_ready;
  logic [N:0]   out_sum;
`ifdef CLA_ISSUE_STATS_EN
  cla_stat_t    stat_ops, stat_carry;
`endif

  cla_issue_ctrl #(.N(N), .ADD_LAT(ADD_LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
`ifdef CLA_ISSUE_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_carry(stat_carry)
`endif
  );

  // Adder model: sum of the operands presented in cycle t is on add_sum in
  // cycle t+ADD_LAT-1, i.e. ADD_LAT-1 register stages. Reset clears it.
  logic [N:0] add_pipe [ADD_LAT-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ADD_LAT - 1; k++) add_pipe[k] <= '0;
    end else begin
      add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
      for (int k = 1; k < ADD_LAT - 1; k++) add_pipe[k] <= add_pipe[k-1];
    end
  end
  assign add_sum = add_pipe[ADD_LAT-2];

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [N:0]  exp_q[$];
  logic [N:0]  drv_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Input monitor: an accept pushes the expected sum; operands must pass
  // straight to the adder, and a refused request must present zeros.
  always @(negedge clk) begin
    if (!reset && in_valid) begin
      if (in_ready) begin
        exp_q.push_back(drv_exp);
        chk("add_a_pass", add_a, in_a);
        chk("add_b_pass", add_b, in_b);
      end else begin
        chk("add_a_idle", add_a, 0);
        chk("add_b_idle", add_b, 0);
      end
    end
  end

  // Output monitor: pop-and-compare, plus head stability under backpressure.
  logic       held_v = 1'b0;
  logic [N:0] held_s;
  logic [N:0] exp_s;
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) chk("out_sum_hold", out_sum, held_s);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %0h expected no output at t=%0t", out_sum, $time);
        end else begin
          exp_s = exp_q.pop_front();
          chk("out_sum", out_sum, exp_s);
        end
      end
      held_v = out_valid && !out_ready;
      held_s = out_sum;
    end
  end

  // ---------------- hand-computed vectors ----------------
  localparam logic [3:0] BP_A [8] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  localparam logic [3:0] BP_B [8] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
  localparam logic [4:0] BP_S [8] = '{5'h03, 5'h06, 5'h09, 5'h0C, 5'h0F, 5'h12, 5'h15, 5'h18};

  localparam logic [3:0] WP_A [4] = '{4'd1, 4'd2, 4'd9, 4'd12};
  localparam logic [3:0] WP_B [4] = '{4'd1, 4'd3, 4'd9, 4'd13};
  localparam logic [4:0] WP_S [4] = '{5'h02, 5'h05, 5'h12, 5'h19};

  localparam logic [3:0] RS_A [5] = '{4'd0, 4'd3, 4'd15, 4'd6, 4'd11};
  localparam logic [3:0] RS_B [5] = '{4'd1, 4'd3, 4'd14, 4'd9, 4'd5};
  localparam logic [4:0] RS_S [5] = '{5'h01, 5'h06, 5'h1D, 5'h0F, 5'h10};

  localparam logic [3:0] ST_A [3] = '{4'd8, 4'd1, 4'd15};
  localparam logic [3:0] ST_B [3] = '{4'd8, 4'd2, 4'd15};
  localparam logic [4:0] ST_S [3] = '{5'h10, 5'h03, 5'h1E};

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; drv_exp = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
`ifdef CLA_ISSUE_STATS_EN
    chk("rst_stat_ops", stat_ops, 0);
    chk("rst_stat_carry", stat_carry, 0);
`endif

    // Single op F+1, accepted in cycle 0: visible only in cycle 5.
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk); #1;
      in_valid = (c == 0); in_a = 4'hF; in_b = 4'h1; drv_exp = 5'h10; out_ready = 1'b1;
      @(negedge clk);
      if (c == 0) chk("single_in_ready", in_ready, 1);
      chk("single_out_valid", out_valid, (c == 5));
      chk("single_out_sum", out_sum, (c == 5) ? 5'h10 : 5'h00);
    end

    // Back-to-back (i, 15-i): full throughput, 16 consecutive results.
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 16); in_a = 4'(c); in_b = 4'(15 - c); drv_exp = 5'h0F; out_ready = 1'b1;
      @(negedge clk);
      if (c < 16) chk("b2b_in_ready", in_ready, 1);
      chk("b2b_out_valid", out_valid, (c >= 5 && c <= 20));
    end

    // Backpressure: exactly DEPTH accepts, then drain; credit back next cycle.
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 12);
      if (c < 8) begin in_a = BP_A[c]; in_b = BP_B[c]; drv_exp = BP_S[c]; end
      out_ready = (c >= 12);
      @(negedge clk);
      chk("bp_in_ready", in_ready, (c < 8 || c >= 13));
      chk("bp_out_valid", out_valid, (c >= 5 && c <= 19));
    end

    // Write and pop together at count 3 (cycle 7): count must stay 3.
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 4);
      if (c < 4) begin in_a = WP_A[c]; in_b = WP_B[c]; drv_exp = WP_S[c]; end
      out_ready = (c == 7) || (c >= 10);
      @(negedge clk);
      if (c < 4) chk("wp_in_ready", in_ready, 1);
      chk("wp_out_valid", out_valid, (c >= 5 && c <= 12));
    end
    chk("wp_queue_empty", exp_q.size(), 0);

    // Reset for one cycle with 2 results stored and 3 ops in flight.
    for (int c = 0; c <= 18; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 5);
      if (c < 5) begin in_a = RS_A[c]; in_b = RS_B[c]; drv_exp = RS_S[c]; end
      reset = (c == 6);
      if (c == 6) exp_q.delete();
      out_ready = (c >= 7);
      @(negedge clk);
      if (c == 5) chk("rs_pre_out_valid", out_valid, 1);
      if (c == 6) chk("rs_during_in_ready", in_ready, 0);
      if (c == 7) begin
        chk("rs_in_ready", in_ready, 1);
        chk("rs_out_sum", out_sum, 0);
      end
      if (c >= 7) chk("rs_out_valid", out_valid, 0);
    end

    // Carry and no-carry results after reset; these also feed the stats.
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 3);
      if (c < 3) begin in_a = ST_A[c]; in_b = ST_B[c]; drv_exp = ST_S[c]; end
      out_ready = 1'b1;
      @(negedge clk);
      chk("st_out_valid", out_valid, (c >= 5 && c <= 7));
    end
`ifdef CLA_ISSUE_STATS_EN
    chk("stat_ops", stat_ops, 3);
    chk("stat_carry", stat_carry, 2);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cla_issue_ctrl
